// File: rtl/automat_pkg.sv
// rtl/automat_pkg.sv - shared types and constants for the automat vending controller
//
// Purpose: FSM state encoding, coin values, register widths and the coin
//          priority decode used by automat.
// Contents:
//   state_t     - COLLECT / DISPENSE / CHANGE
//   CREDIT_W    - credit register width (5 bits)
//   CHANGE_W    - change register width (4 bits)
//   VAL_1/5/10  - coin values in lei
//   coin_value  - priority decode of {LEI10, LEI5, LEU1} to a value
package automat_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  localparam int CREDIT_W = 5;
  localparam int CHANGE_W = 4;

  localparam logic [CREDIT_W-1:0] VAL_1  = 5'd1;
  localparam logic [CREDIT_W-1:0] VAL_5  = 5'd5;
  localparam logic [CREDIT_W-1:0] VAL_10 = 5'd10;

  // coins = {lei10, lei5, leu1}; the highest coin wins, the others are dropped.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] coins);
    logic [CREDIT_W-1:0] v;
    v = '0;
    if (coins[2])      v = VAL_10;
    else if (coins[1]) v = VAL_5;
    else if (coins[0]) v = VAL_1;
    return v;
  endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// rtl/coin_edge_detect.sv - registered rising-edge detector for the three coin inputs
//
// Purpose: turns level coin inputs into one-cycle pulses, one per low-to-high
//          transition. The inputs are registered first, so a pulse appears one
//          cycle after the input rises.
// Ports:
//   i_clk   in  1 : system clock
//   i_rst   in  1 : asynchronous active-high reset
//   i_coin  in  3 : {LEI10, LEI5, LEU1} levels
//   o_rise  out 3 : one-cycle rising-edge pulses, same bit order
module coin_edge_detect (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_coin,
  output logic [2:0] o_rise
);

  logic [2:0] r_coin;
  logic [2:0] r_coin_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_coin   <= '0;
      r_coin_d <= '0;
    end else begin
      r_coin   <= i_coin;
      r_coin_d <= r_coin;
    end
  end

  assign o_rise = r_coin & ~r_coin_d;

endmodule

// File: rtl/automat.sv
// rtl/automat.sv - beverage vending-machine controller (credit, bottle, change)
//
// Purpose: accumulates 1/5/10 lei coins, releases one bottle when credit
//          reaches PRICE, then pays change back as 5-lei and 1-leu pulses.
// Build option: AUTOMAT_COIN_EDGE_EN - when defined, coins count once per
//          rising edge (through coin_edge_detect, one extra cycle latency);
//          otherwise every COLLECT edge with a coin high counts a coin.
// Parameters:
//   PRICE          : bottle price in lei, 1..15
// Ports:
//   clk            in  1 : system clock
//   reset          in  1 : asynchronous active-high reset
//   LEU1           in  1 : 1-leu coin present
//   LEI5           in  1 : 5-lei coin present
//   LEI10          in  1 : 10-lei coin present
//   REST1          out 1 : eject one 1-leu change coin
//   REST5          out 1 : eject one 5-lei change coin
//   PLEACA_STICLA  out 1 : release one bottle
module automat
  import automat_pkg::*;
#(
  parameter int PRICE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic LEU1,
  input  logic LEI5,
  input  logic LEI10,
  output logic REST1,
  output logic REST5,
  output logic PLEACA_STICLA
);

  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);

  state_t                r_state;
  state_t                w_state_next;
  logic [CREDIT_W-1:0]   r_credit;
  logic [CREDIT_W-1:0]   w_credit_next;
  logic [CHANGE_W-1:0]   r_change;
  logic [CHANGE_W-1:0]   w_change_next;
  logic [CHANGE_W-1:0]   w_change_dec;
  logic [2:0]            w_coin_lvl;
  logic [2:0]            w_coin_evt;
  logic [CREDIT_W-1:0]   w_value;
  logic [CREDIT_W-1:0]   w_sum;
  logic                  w_pay5;

  assign w_coin_lvl = {LEI10, LEI5, LEU1};

`ifdef AUTOMAT_COIN_EDGE_EN
  coin_edge_detect u_coin_edge (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_coin (w_coin_lvl),
    .o_rise (w_coin_evt)
  );
`else
  assign w_coin_evt = w_coin_lvl;
`endif

  // credit never exceeds PRICE-1 (14) before a coin, so credit+10 fits 5 bits
  assign w_value      = coin_value(w_coin_evt);
  assign w_sum        = r_credit + w_value;
  assign w_pay5       = (r_change >= CHANGE_W'(5));
  assign w_change_dec = r_change - (w_pay5 ? CHANGE_W'(5) : CHANGE_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= COLLECT;
      r_credit <= '0;
      r_change <= '0;
    end else begin
      r_state  <= w_state_next;
      r_credit <= w_credit_next;
      r_change <= w_change_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_change_next = r_change;
    case (r_state)
      COLLECT: begin
        // with no coin the sum equals credit, which is always below PRICE
        if (w_sum >= PRICE_V) begin
          w_state_next  = DISPENSE;
          w_credit_next = '0;
          w_change_next = CHANGE_W'(w_sum - PRICE_V);
        end else begin
          w_credit_next = w_sum;
        end
      end
      DISPENSE: begin
        w_state_next = (r_change != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        w_change_next = w_change_dec;
        if (w_change_dec == '0) w_state_next = COLLECT;
      end
      default: begin
        w_state_next  = COLLECT;
        w_credit_next = '0;
        w_change_next = '0;
      end
    endcase
  end

  // Moore decode: outputs follow the registered state, so reset clears them
  // asynchronously along with the state.
  always_comb begin
    PLEACA_STICLA = 1'b0;
    REST5         = 1'b0;
    REST1         = 1'b0;
    case (r_state)
      DISPENSE: PLEACA_STICLA = 1'b1;
      CHANGE: begin
        REST5 = w_pay5;
        REST1 = ~w_pay5;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_automat.sv
// tb/tb_automat.sv - scoreboard testbench for automat with a transaction-level model
module tb_automat;

  localparam int PRICE = 3;

  logic clk = 1'b0;
  logic reset;
  logic LEU1, LEI5, LEI10;
  logic REST1, REST5, PLEACA_STICLA;

  automat #(.PRICE(PRICE)) dut (
    .clk           (clk),
    .reset         (reset),
    .LEU1          (LEU1),
    .LEI5          (LEI5),
    .LEI10         (LEI10),
    .REST1         (REST1),
    .REST5         (REST5),
    .PLEACA_STICLA (PLEACA_STICLA)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected output codes, bit order {REST5, REST1, PLEACA_STICLA}
  localparam logic [2:0] EV_BOTTLE = 3'b001;
  localparam logic [2:0] EV_R1     = 3'b010;
  localparam logic [2:0] EV_R5     = 3'b100;

  typedef struct {
    logic [2:0] code;
    int         cyc;
  } ev_t;

  ev_t sb[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_credit;
  int         m_busy;
  logic [2:0] m_prev;
  logic [2:0] m_pend;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_credit = 0;
    m_busy   = 0;
    m_prev   = '0;
    m_pend   = '0;
  endtask

  // One clock edge of the machine as a vending transaction; c = {10, 5, 1}.
  task automatic model_step(input logic [2:0] c);
    logic [2:0] evt;
    int v, sum, chg, t;
`ifdef AUTOMAT_COIN_EDGE_EN
    evt    = m_pend;
    m_pend = c & ~m_prev;
    m_prev = c;
`else
    evt = c;
`endif
    if (m_busy > 0) begin
      m_busy--;
      return;
    end
    v   = evt[2] ? 10 : evt[1] ? 5 : evt[0] ? 1 : 0;
    sum = m_credit + v;
    if (sum >= PRICE) begin
      chg      = sum - PRICE;
      m_credit = 0;
      t        = cyc + 1;
      sb.push_back('{EV_BOTTLE, t});
      for (int i = 0; i < chg / 5; i++) begin t++; sb.push_back('{EV_R5, t}); end
      for (int i = 0; i < chg % 5; i++) begin t++; sb.push_back('{EV_R1, t}); end
      m_busy = 1 + chg / 5 + chg % 5;
    end else begin
      m_credit = sum;
    end
  endtask

  task automatic step(input logic [2:0] c);
    @(negedge clk);
    check("credit", int'(dut.r_credit), m_credit);
    {LEI10, LEI5, LEU1} = c;
    model_step(c);
  endtask

  task automatic hold_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      {LEI10, LEI5, LEU1} = 3'($urandom);
      check("reset_outputs", int'({REST5, REST1, PLEACA_STICLA}), 0);
      check("reset_credit", int'(dut.r_credit), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    {LEI10, LEI5, LEU1} = 3'b000;
    model_step(3'b000);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    model_clear();
    {LEI10, LEI5, LEU1} = 3'($urandom);
    #1;
    check("reset_async_outputs", int'({REST5, REST1, PLEACA_STICLA}), 0);
    hold_reset(n);
  endtask

  // monitor: every non-reset cycle the outputs must equal the scheduled event
  logic [2:0] mon_obs;
  logic [2:0] mon_exp;
  always @(negedge clk) begin
    if (!reset) begin
      mon_obs = {REST5, REST1, PLEACA_STICLA};
      mon_exp = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_exp = sb[0].code;
        void'(sb.pop_front());
      end
      check("outputs", int'(mon_obs), int'(mon_exp));
    end
  end

  logic [2:0] rc;
  int         r;

  initial begin
    reset = 1'b1;
    {LEI10, LEI5, LEU1} = 3'b000;
    model_clear();
    hold_reset(3);

    // three 1-leu coins: credit 1, 2, then bottle with no change
    repeat (3) step(3'b001);
    repeat (3) step(3'b000);

    // 5 lei: bottle then two REST1
    step(3'b010);
    repeat (4) step(3'b000);

    // 10 lei: bottle, one REST5, two REST1
    step(3'b100);
    repeat (6) step(3'b000);

    // 10 lei and 1 leu together: only the 10 counts
    step(3'b101);
    repeat (6) step(3'b000);

    // reset during change, right after the REST5 pulse
    step(3'b100);
    step(3'b000);
    step(3'b000);
    do_reset(2);
    step(3'b001);
    repeat (3) step(3'b000);

`ifdef AUTOMAT_COIN_EDGE_EN
    do_reset(1);
    repeat (5) step(3'b001);
    repeat (2) step(3'b000);
    check("edge_held_coin_credit", int'(dut.r_credit), 1);
`endif

    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(1 + ($urandom % 2));
      end else begin
        rc = (r < 55) ? 3'b000 : 3'($urandom);
        step(rc);
      end
    end

    repeat (10) step(3'b000);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
